// File: rtl/sigdelay_pkg.sv
// Shared types and defaults for the sample delay/capture path.
package sigdelay_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StArmed,
    StCapture,
    StDone
  } state_t;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 8;

endpackage

// File: rtl/ram2port.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the previous contents.
module ram2port #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  // Contents come up zeroed at configuration and are never cleared by reset.
  logic [DataWidth-1:0] mem_q [Depth] = '{default: '0};
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_delay_writer.sv
// Captures a sample stream into a circular RAM and reads it back delayed by a programmable
// offset, with an optional triggered one-shot capture followed by sequential playback.
module sample_delay_writer
  import sigdelay_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned DataWidth = DefDataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 oneshot_i,
  input  logic                 trig_i,
  input  logic [DataWidth-1:0] sample_in_i,
  input  logic [AddrWidth-1:0] offset_i,
  output logic [DataWidth-1:0] dout_o,
  output logic                 dout_valid_o,
  output logic [AddrWidth-1:0] wr_ptr_o,
  output logic [AddrWidth:0]   fill_count_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [AddrWidth:0] FillMax = {1'b1, {AddrWidth{1'b0}}};

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] play_ptr_q, play_ptr_d;
  logic [AddrWidth:0]   fill_q, fill_d;
  logic                 dout_valid_q;
  logic                 busy_q, done_q;

  logic                 wr_en, rd_en;
  logic [AddrWidth-1:0] wr_addr, rd_addr;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    play_ptr_d = play_ptr_q;
    fill_d     = fill_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wr_addr    = wr_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = oneshot_i ? StArmed : StRun;
          fill_d  = '0;
        end
      end
      StRun, StCapture: begin
        if (en_i) begin
          wr_en = 1'b1;
          rd_en = 1'b1;
        end
      end
      StArmed: begin
        // The trigger cycle's sample, if any, becomes the first captured sample at address 0.
        if (trig_i) begin
          state_d  = StCapture;
          wr_ptr_d = '0;
          wr_addr  = '0;
          if (en_i) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
          end
        end
      end
      StDone: begin
        if (en_i) begin
          rd_en      = 1'b1;
          play_ptr_d = play_ptr_q + 1'b1;
        end
        if (start_i) begin
          state_d = oneshot_i ? StArmed : StRun;
          fill_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_addr + 1'b1;
      if (fill_q != FillMax) begin
        fill_d = fill_q + 1'b1;
      end
      if (state_q == StCapture && fill_q == FillMax - 1'b1) begin
        state_d    = StDone;
        play_ptr_d = '0;
      end
    end

    if (stop_i) begin
      state_d = StIdle;
    end
  end

  assign rd_addr = (state_q == StDone) ? play_ptr_q : wr_addr - offset_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      play_ptr_q   <= '0;
      fill_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      play_ptr_q   <= play_ptr_d;
      fill_q       <= fill_d;
      dout_valid_q <= rd_en;
      busy_q       <= (state_d == StArmed) || (state_d == StCapture);
      done_q       <= (state_d == StDone);
    end
  end

  ram2port #(
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (wr_en & ~rst_i),
    .waddr_i(wr_addr),
    .wdata_i(sample_in_i),
    .re_i   (rd_en & ~rst_i),
    .raddr_i(rd_addr),
    .rdata_o(dout_o)
  );

  assign dout_valid_o = dout_valid_q;
  assign wr_ptr_o     = wr_ptr_q;
  assign fill_count_o = fill_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_sample_delay_writer.sv
// Directed bench for sample_delay_writer: continuous delay, collisions, one-shot, wrap, reset.
module tb_sample_delay_writer;

  logic       clk = 1'b0;
  logic       rst, en, start, stop, oneshot, trig;
  logic [7:0] sample_in, offset;
  logic [7:0] dout;
  logic       dout_valid;
  logic [7:0] wr_ptr;
  logic [8:0] fill_count;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_delay_writer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .start_i     (start),
    .stop_i      (stop),
    .oneshot_i   (oneshot),
    .trig_i      (trig),
    .sample_in_i (sample_in),
    .offset_i    (offset),
    .dout_o      (dout),
    .dout_valid_o(dout_valid),
    .wr_ptr_o    (wr_ptr),
    .fill_count_o(fill_count),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0; trig = 1'b0;
    sample_in = 8'h00; offset = 8'h00;

    // Reset
    tick(); tick();
    rst = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_fill", fill_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrptr", wr_ptr, 0);

    // Continuous mode, offset 3
    start = 1'b1; oneshot = 1'b0; tick(); start = 1'b0;
    offset = 8'd3; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_in = 8'h10 + 8'(i);
      tick();
    end
    check("run_dout", dout, 8'h10);
    check("run_valid", dout_valid, 1);
    en = 1'b0; tick();
    check("run_valid_pulse", dout_valid, 0);
    check("run_dout_hold", dout, 8'h10);
    check("run_wrptr", wr_ptr, 4);
    check("run_fill", fill_count, 4);

    // offset 0: read returns old data
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    offset = 8'd0; en = 1'b1;
    sample_in = 8'h00; tick();
    check("rdw_old_first", dout, 8'h10);
    for (int i = 1; i < 256; i++) begin
      sample_in = 8'(i);
      tick();
    end
    sample_in = 8'hAA; tick();
    check("rdw_old_wrap", dout, 8'h00);
    check("rdw_fill_256", fill_count, 256);
    check("rdw_wrptr", wr_ptr, 1);
    sample_in = 8'hBB; tick();
    check("fill_saturate", fill_count, 256);
    check("rdw_addr1", dout, 8'h01);
    en = 1'b0;

    // One-shot capture and playback
    do_reset();
    start = 1'b1; oneshot = 1'b1; tick(); start = 1'b0; oneshot = 1'b0;
    check("armed_busy", busy, 1);
    en = 1'b1; sample_in = 8'h77;
    for (int i = 0; i < 10; i++) tick();
    check("armed_wrptr", wr_ptr, 0);
    check("armed_fill", fill_count, 0);
    check("armed_noread", dout_valid, 0);
    trig = 1'b1; sample_in = 8'h55; tick(); trig = 1'b0;
    check("trig_wrptr", wr_ptr, 1);
    check("trig_fill", fill_count, 1);
    check("cap_busy", busy, 1);
    for (int i = 1; i < 256; i++) begin
      sample_in = 8'(i) ^ 8'h3C;
      tick();
    end
    check("cap_done", done, 1);
    check("cap_busy_clr", busy, 0);
    check("cap_fill", fill_count, 256);
    sample_in = 8'hEE; offset = 8'h07;
    tick();
    check("play0", dout, 8'h55);
    check("play0_valid", dout_valid, 1);
    tick();
    check("play1", dout, 8'h3D);
    check("done_wrptr", wr_ptr, 0);
    check("done_fill", fill_count, 256);
    en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    check("stop_done", done, 0);
    start = 1'b1; tick(); start = 1'b0;
    offset = 8'd0; en = 1'b1; sample_in = 8'h01; tick();
    check("done_nowrite", dout, 8'h55);
    en = 1'b0;

    // Wrap in RUN, then start+stop together
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sample_in = 8'(i);
      tick();
    end
    check("wrap_wrptr", wr_ptr, 44);
    check("wrap_fill", fill_count, 256);
    en = 1'b0; start = 1'b1; stop = 1'b1; tick();
    start = 1'b0; stop = 1'b0;
    en = 1'b1; tick(); tick(); en = 1'b0;
    check("stop_wrptr", wr_ptr, 44);
    check("stop_noread", dout_valid, 0);
    start = 1'b1; stop = 1'b1; tick();
    start = 1'b0; stop = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    check("idle_startstop", wr_ptr, 44);
    check("idle_busy", busy, 0);

    // Reset mid-capture
    do_reset();
    start = 1'b1; oneshot = 1'b1; tick(); start = 1'b0; oneshot = 1'b0;
    trig = 1'b1; en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sample_in = 8'(i) + 8'h80;
      tick();
      trig = 1'b0;
    end
    en = 1'b0;
    check("cap100_fill", fill_count, 100);
    do_reset();
    check("abort_busy", busy, 0);
    check("abort_fill", fill_count, 0);
    check("abort_wrptr", wr_ptr, 0);
    start = 1'b1; tick(); start = 1'b0;
    offset = 8'h9C; en = 1'b1; sample_in = 8'h01; tick();
    check("retain_0x64", dout, 8'h64);
    offset = 8'h9E; tick();
    check("retain_partial", dout, 8'hE3);
    en = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
